// File: rtl/muldiv_hilo_sequencer.sv
// HI/LO sequencer: runs one multiply/divide/move at a time, drives the ALU start
// pulses and owns every HI/LO write enable. All outputs are registered.
module muldiv_hilo_sequencer #(
    parameter int TIMEOUT_CYCLES = 40,
    parameter int CNT_WIDTH      = 6
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       req_valid,
    input  logic [2:0] req_op,
    input  logic       divisor_zero,
    input  logic       mult_div_done,
    output logic       req_ready,
    output logic       mult_start,
    output logic       div_start,
    output logic       md_signed,
    output logic       hi_SEL,
    output logic       hi_EN,
    output logic       lo_SEL,
    output logic       lo_EN,
    output logic       busy,
    output logic       op_done,
    output logic       err_div0,
    output logic       err_timeout
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_WAIT  = 3'd2,
        ST_WRITE = 3'd3,
        ST_MOVE  = 3'd4,
        ST_ERR   = 3'd5
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_MAX  = CNT_WIDTH'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_ZERO = '0;

    state_t               state_r, state_next_s;
    logic [CNT_WIDTH-1:0] cnt_r, cnt_next_s;
    logic [2:0]           op_r, op_next_s;
    logic                 accept_s;

    logic is_mult_s, is_div_s, is_signed_s;
    logic mult_start_s, div_start_s, md_signed_s;
    logic hi_sel_s, hi_en_s, lo_sel_s, lo_en_s;
    logic busy_s, op_done_s, err_div0_s, err_timeout_s;

    assign accept_s = req_valid & req_ready;

    // Next-state, counter and latched-operation logic
    always_comb begin
        state_next_s = state_r;
        cnt_next_s   = cnt_r;
        op_next_s    = op_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    op_next_s = req_op;
                    if (req_op[2]) begin
                        state_next_s = ST_MOVE;
                    end else if (req_op[1] && divisor_zero) begin
                        state_next_s = ST_ERR;
                    end else begin
                        state_next_s = ST_START;
                    end
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_START: begin
                cnt_next_s   = CNT_ZERO;
                state_next_s = ST_WAIT;
            end
            ST_WAIT: begin
                // done takes priority over an expiring timeout
                if (mult_div_done) begin
                    state_next_s = ST_WRITE;
                end else if (cnt_r == CNT_MAX) begin
                    state_next_s = ST_ERR;
                end else begin
                    cnt_next_s = cnt_r + CNT_ONE;
                end
            end
            ST_WRITE: state_next_s = ST_IDLE;
            ST_MOVE:  state_next_s = ST_IDLE;
            ST_ERR:   state_next_s = ST_IDLE;
            default:  state_next_s = ST_IDLE;
        endcase
    end

    // Output decode from the upcoming state so the registered outputs line up with it
    always_comb begin
        is_mult_s     = ~op_next_s[2] & ~op_next_s[1];
        is_div_s      = ~op_next_s[2] &  op_next_s[1];
        is_signed_s   = ~op_next_s[2] & ~op_next_s[0];
        mult_start_s  = (state_next_s == ST_START) & is_mult_s;
        div_start_s   = (state_next_s == ST_START) & is_div_s;
        md_signed_s   = ((state_next_s == ST_START) | (state_next_s == ST_WAIT)) & is_signed_s;
        hi_sel_s      = (state_next_s == ST_WRITE);
        lo_sel_s      = (state_next_s == ST_WRITE);
        hi_en_s       = (state_next_s == ST_WRITE) | ((state_next_s == ST_MOVE) & (op_next_s == 3'd4));
        lo_en_s       = (state_next_s == ST_WRITE) | ((state_next_s == ST_MOVE) & (op_next_s == 3'd5));
        busy_s        = (state_next_s != ST_IDLE);
        op_done_s     = (state_next_s == ST_WRITE) | (state_next_s == ST_MOVE) | (state_next_s == ST_ERR);
        err_div0_s    = (state_next_s == ST_ERR) & (state_r == ST_IDLE);
        err_timeout_s = (state_next_s == ST_ERR) & (state_r == ST_WAIT);
    end

    // State, counter, latched op and registered outputs
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r     <= ST_IDLE;
            cnt_r       <= CNT_ZERO;
            op_r        <= 3'd0;
            req_ready   <= 1'b1;
            mult_start  <= 1'b0;
            div_start   <= 1'b0;
            md_signed   <= 1'b0;
            hi_SEL      <= 1'b0;
            hi_EN       <= 1'b0;
            lo_SEL      <= 1'b0;
            lo_EN       <= 1'b0;
            busy        <= 1'b0;
            op_done     <= 1'b0;
            err_div0    <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            cnt_r       <= cnt_next_s;
            op_r        <= op_next_s;
            req_ready   <= ~busy_s;
            mult_start  <= mult_start_s;
            div_start   <= div_start_s;
            md_signed   <= md_signed_s;
            hi_SEL      <= hi_sel_s;
            hi_EN       <= hi_en_s;
            lo_SEL      <= lo_sel_s;
            lo_EN       <= lo_en_s;
            busy        <= busy_s;
            op_done     <= op_done_s;
            err_div0    <= err_div0_s;
            err_timeout <= err_timeout_s;
        end
    end

endmodule

// File: tb/tb_muldiv_hilo_sequencer.sv
// Directed-vector bench for muldiv_hilo_sequencer; outputs are packed as
// {req_ready, mult_start, div_start, md_signed, hi_SEL, hi_EN, lo_SEL, lo_EN, busy, op_done, err_div0, err_timeout}.
module tb_muldiv_hilo_sequencer;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       req_valid = 1'b0;
    logic [2:0] req_op = 3'd0;
    logic       divisor_zero = 1'b0;
    logic       mult_div_done = 1'b0;
    logic       req_ready, mult_start, div_start, md_signed;
    logic       hi_SEL, hi_EN, lo_SEL, lo_EN;
    logic       busy, op_done, err_div0, err_timeout;

    int n_vec = 0;
    int n_err = 0;

    localparam logic [11:0] V_IDLE   = 12'b1000_0000_0000;
    localparam logic [11:0] V_MTHI   = 12'b0000_0100_1100;
    localparam logic [11:0] V_MTLO   = 12'b0000_0001_1100;
    localparam logic [11:0] V_MFX    = 12'b0000_0000_1100;
    localparam logic [11:0] V_WRITE  = 12'b0000_1111_1100;
    localparam logic [11:0] V_ERR_D0 = 12'b0000_0000_1110;
    localparam logic [11:0] V_ERR_TO = 12'b0000_0000_1101;
    localparam logic [11:0] V_ST_M   = 12'b0101_0000_1000;
    localparam logic [11:0] V_ST_MU  = 12'b0100_0000_1000;
    localparam logic [11:0] V_ST_D   = 12'b0011_0000_1000;
    localparam logic [11:0] V_ST_DU  = 12'b0010_0000_1000;
    localparam logic [11:0] V_WT_S   = 12'b0001_0000_1000;
    localparam logic [11:0] V_WT_U   = 12'b0000_0000_1000;

    muldiv_hilo_sequencer #(.TIMEOUT_CYCLES(40), .CNT_WIDTH(6)) dut (
        .CLK(CLK), .RST(RST), .req_valid(req_valid), .req_op(req_op),
        .divisor_zero(divisor_zero), .mult_div_done(mult_div_done),
        .req_ready(req_ready), .mult_start(mult_start), .div_start(div_start),
        .md_signed(md_signed), .hi_SEL(hi_SEL), .hi_EN(hi_EN), .lo_SEL(lo_SEL),
        .lo_EN(lo_EN), .busy(busy), .op_done(op_done), .err_div0(err_div0),
        .err_timeout(err_timeout)
    );

    always #5 CLK = ~CLK;

    function automatic logic [11:0] outs();
        return {req_ready, mult_start, div_start, md_signed, hi_SEL, hi_EN,
                lo_SEL, lo_EN, busy, op_done, err_div0, err_timeout};
    endfunction

    task automatic check_vec(input string tag, input logic [11:0] got, input logic [11:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        tick();
        tick();
        check_vec("reset_held", outs(), V_IDLE);
        RST = 1'b0;
        tick();
        check_vec("idle", outs(), V_IDLE);

        // MTHI, then MTLO and MFHI
        req_valid = 1'b1; req_op = 3'd4;
        tick();
        check_vec("mthi_move", outs(), V_MTHI);
        req_valid = 1'b0;
        tick();
        check_vec("mthi_ready", outs(), V_IDLE);
        req_valid = 1'b1; req_op = 3'd5;
        tick();
        check_vec("mtlo_move", outs(), V_MTLO);
        req_op = 3'd6;
        tick();
        check_vec("mtlo_idle", outs(), V_IDLE);
        tick();
        check_vec("mfhi_move", outs(), V_MFX);
        req_valid = 1'b0;
        tick();
        check_vec("mfhi_idle", outs(), V_IDLE);

        // MULT, done on the 5th WAIT cycle
        req_valid = 1'b1; req_op = 3'd0;
        tick();
        check_vec("mult_start", outs(), V_ST_M);
        req_valid = 1'b0; req_op = 3'd5;
        for (int i = 1; i <= 5; i++) begin
            tick();
            check_vec($sformatf("mult_wait%0d", i), outs(), V_WT_S);
        end
        mult_div_done = 1'b1;
        tick();
        check_vec("mult_write", outs(), V_WRITE);
        mult_div_done = 1'b0;
        tick();
        check_vec("mult_idle", outs(), V_IDLE);

        // DIVU with zero divisor
        req_valid = 1'b1; req_op = 3'd3; divisor_zero = 1'b1;
        tick();
        check_vec("divu_div0", outs(), V_ERR_D0);
        req_valid = 1'b0; divisor_zero = 1'b0;
        tick();
        check_vec("divu_div0_idle", outs(), V_IDLE);

        // DIV never completes: 40 WAIT cycles then timeout
        req_valid = 1'b1; req_op = 3'd2;
        tick();
        check_vec("div_start", outs(), V_ST_D);
        req_valid = 1'b0; divisor_zero = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            tick();
            check_vec($sformatf("div_wait%0d", i), outs(), V_WT_S);
        end
        tick();
        check_vec("div_timeout", outs(), V_ERR_TO);
        divisor_zero = 1'b0;
        tick();
        check_vec("div_timeout_idle", outs(), V_IDLE);

        // DIVU: done coincides with the last WAIT cycle, done wins
        req_valid = 1'b1; req_op = 3'd3;
        tick();
        check_vec("divu_start", outs(), V_ST_DU);
        req_valid = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            tick();
            check_vec($sformatf("divu_wait%0d", i), outs(), V_WT_U);
        end
        mult_div_done = 1'b1;
        tick();
        check_vec("divu_edge_write", outs(), V_WRITE);
        mult_div_done = 1'b0;

        // back-to-back: accepted in the IDLE cycle right after op_done
        req_valid = 1'b1; req_op = 3'd5;
        tick();
        check_vec("b2b_idle", outs(), V_IDLE);
        tick();
        check_vec("b2b_mtlo", outs(), V_MTLO);
        req_valid = 1'b0;
        tick();

        // stray done in IDLE and START is ignored
        mult_div_done = 1'b1;
        tick();
        check_vec("stray_done_idle", outs(), V_IDLE);
        req_valid = 1'b1; req_op = 3'd1;
        tick();
        check_vec("multu_start", outs(), V_ST_MU);
        req_valid = 1'b0;
        tick();
        check_vec("multu_wait_after_stray", outs(), V_WT_U);
        mult_div_done = 1'b0;
        tick();
        check_vec("multu_wait2", outs(), V_WT_U);

        // reset during WAIT, then late done
        RST = 1'b1;
        tick();
        check_vec("rst_abort", outs(), V_IDLE);
        RST = 1'b0;
        mult_div_done = 1'b1;
        tick();
        check_vec("late_done_idle", outs(), V_IDLE);
        mult_div_done = 1'b0;
        tick();
        check_vec("late_done_idle2", outs(), V_IDLE);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
